// File: rtl/wb_cmd_master_pkg.sv
// Shared state type and constants for the Wishbone command master and its timeout counter.
package wb_cmd_master_pkg;

   typedef enum logic [1:0] {
      IDLE,
      WDATA,
      BUS,
      RSP
   } state_t;

   localparam int unsigned WB_STRIDE = 4;

   // Wide enough for the largest TIMEOUT the master accepts (1023).
   localparam int TIMEOUT_MAX = 1023;
   localparam int TO_W = $clog2(TIMEOUT_MAX + 1);

endpackage

// File: rtl/wb_cmd_master_if.sv
// Command, write-data and read-response streams plus the Wishbone initiator bus.
interface wb_cmd_master_if;

   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_we;
   logic [31:0] cmd_adr;
   logic [3:0]  cmd_sel;
   logic [7:0]  cmd_len;

   logic        wr_valid;
   logic        wr_ready;
   logic [31:0] wr_data;

   logic        rd_valid;
   logic        rd_ready;
   logic [31:0] rd_data;

   logic        done;
   logic        err;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic [31:0] wbm_dat_i;
   logic        wbm_ack_i;

   modport master (
      input  cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
      input  wr_valid, wr_data, rd_ready, wbm_dat_i, wbm_ack_i,
      output cmd_ready, wr_ready, rd_valid, rd_data, done, err,
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );

   modport slave (
      output cmd_valid, cmd_we, cmd_adr, cmd_sel, cmd_len,
      output wr_valid, wr_data, rd_ready, wbm_dat_i, wbm_ack_i,
      input  cmd_ready, wr_ready, rd_valid, rd_data, done, err,
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o
   );

endinterface

// File: rtl/wb_cmd_master_timeout_cnt.sv
// Per-beat ack watchdog: counts bus cycles spent waiting for ack.
module wbm_timeout_cnt
   import wb_cmd_master_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic expired
);

   logic [TO_W-1:0] count;

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (run) begin
         count <= count + TO_W'(1);
      end
   end

   // Raised in the cycle whose increment brings the count to TIMEOUT, so the
   // abort lands on that same edge; an ack holds run low and therefore wins.
   assign expired = run && (count == TO_W'(TIMEOUT - 1));

endmodule

// File: rtl/wb_cmd_master.sv
// Wishbone classic-cycle initiator: turns command and write-data streams into single or
// incrementing-burst bus beats, returns read data, and aborts a beat on ack timeout.
module wb_cmd_master
   import wb_cmd_master_pkg::*;
#(
   parameter int TIMEOUT = 64
) (
   input logic             clk,
   input logic             rst,
   wb_cmd_master_if.master bus
);

   state_t     state;
   logic [7:0] beats;
   logic       last_beat;
   logic       to_clear;
   logic       to_run;
   logic       to_expired;

   assign bus.cmd_ready = (state == IDLE) && !rst;
   assign bus.wr_ready  = (state == WDATA) && !rst;

   // The counter sits at zero outside BUS, so every beat starts from a fresh count.
   assign to_clear = (state != BUS);
   assign to_run   = (state == BUS) && !bus.wbm_ack_i;

   wbm_timeout_cnt #(
      .TIMEOUT(TIMEOUT)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .clear  (to_clear),
      .run    (to_run),
      .expired(to_expired)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= IDLE;
         beats         <= '0;
         last_beat     <= 1'b0;
         bus.rd_valid  <= 1'b0;
         bus.rd_data   <= '0;
         bus.done      <= 1'b0;
         bus.err       <= 1'b0;
         bus.wbm_cyc_o <= 1'b0;
         bus.wbm_stb_o <= 1'b0;
         bus.wbm_we_o  <= 1'b0;
         bus.wbm_sel_o <= '0;
         bus.wbm_adr_o <= '0;
         bus.wbm_dat_o <= '0;
      end else begin
         bus.done <= 1'b0;
         bus.err  <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.wbm_we_o  <= bus.cmd_we;
                  bus.wbm_adr_o <= bus.cmd_adr;
                  bus.wbm_sel_o <= bus.cmd_sel;
                  beats         <= bus.cmd_len;
                  if (bus.cmd_we) begin
                     state <= WDATA;
                  end else begin
                     state         <= BUS;
                     bus.wbm_cyc_o <= 1'b1;
                     bus.wbm_stb_o <= 1'b1;
                  end
               end
            end
            WDATA: begin
               if (bus.wr_valid) begin
                  bus.wbm_dat_o <= bus.wr_data;
                  bus.wbm_cyc_o <= 1'b1;
                  bus.wbm_stb_o <= 1'b1;
                  state         <= BUS;
               end
            end
            BUS: begin
               if (bus.wbm_ack_i) begin
                  bus.wbm_stb_o <= 1'b0;
                  bus.wbm_adr_o <= bus.wbm_adr_o + 32'(WB_STRIDE);
                  beats         <= beats - 8'd1;
                  last_beat     <= (beats == 8'd0);
                  if (!bus.wbm_we_o) begin
                     bus.rd_data  <= bus.wbm_dat_i;
                     bus.rd_valid <= 1'b1;
                     state        <= RSP;
                  end else if (beats == 8'd0) begin
                     bus.done      <= 1'b1;
                     bus.wbm_cyc_o <= 1'b0;
                     state         <= IDLE;
                  end else begin
                     state <= WDATA;
                  end
               end else if (to_expired) begin
                  bus.wbm_stb_o <= 1'b0;
                  bus.wbm_cyc_o <= 1'b0;
                  bus.err       <= 1'b1;
                  state         <= IDLE;
               end
            end
            RSP: begin
               // last_beat was captured at the ack, since beats has already moved on.
               if (bus.rd_ready) begin
                  bus.rd_valid <= 1'b0;
                  if (last_beat) begin
                     bus.done      <= 1'b1;
                     bus.wbm_cyc_o <= 1'b0;
                     state         <= IDLE;
                  end else begin
                     bus.wbm_stb_o <= 1'b1;
                     state         <= BUS;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/wb_cmd_master.md
# wb_cmd_master

Wishbone classic-cycle initiator that turns simple valid/ready command, write-data and read-response streams into single-word or incrementing-burst bus transactions. It is the master-side counterpart to the user-project Wishbone BRAM responders, which insert multi-cycle ack delays. It sits between a test/DMA sequencer and the user-area Wishbone bus. It enforces a per-beat ack timeout so a dead or undecoded slave cannot hang the sequencer.

## Interface
- TIMEOUT, 64: cycles a beat may wait for ack before abort; range 2..1023.
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when both high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_adr  in  32  start byte address, word aligned.
- cmd_sel  in  4  byte lanes, used for every beat.
- cmd_len  in  8  beats minus one (0 = 1 beat, 255 = 256 beats).
- wr_valid / wr_ready  in / out  1  write-data handshake.
- wr_data  in  32  write beat data.
- rd_valid / rd_ready  out / in  1  read-response handshake.
- rd_data  out  32  read beat data.
- done  out  1  one-cycle pulse, command completed.
- err  out  1  one-cycle pulse, command aborted on timeout.
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1  Wishbone controls.
- wbm_sel_o  out  4, wbm_adr_o  out  32, wbm_dat_o  out  32  Wishbone request.
- wbm_dat_i  in  32, wbm_ack_i  in  1  Wishbone response.

## Operation
- States: IDLE, WDATA, BUS, RSP.
- IDLE: cmd_ready=1. On the cmd handshake, latch we/adr/sel/len and set beat counter = cmd_len.
  - Write command: go to WDATA.
  - Read command: go to BUS.
- WDATA: wr_ready=1. On wr handshake, latch wr_data into wbm_dat_o and go to BUS.
- BUS: wbm_cyc_o=wbm_stb_o=1; wbm_we_o/sel/adr from latched command. On wbm_ack_i:
  - Read: capture wbm_dat_i into rd_data, set rd_valid, go to RSP.
  - Write, last beat: pulse done, go to IDLE.
  - Write, beats remaining: go to WDATA.
  - Every ack: adr += 4 (modulo 2^32), decrement beat counter.
- RSP: hold rd_valid/rd_data until rd_ready.
  - Last beat: pulse done, go to IDLE.
  - Otherwise: go to BUS.
- wbm_cyc_o stays high from the first BUS entry to command end, including the WDATA/RSP gaps. wbm_stb_o is high only in BUS.
- Timeout: a counter clears on BUS entry and increments each BUS cycle without ack. When it reaches TIMEOUT: drop cyc/stb, pulse err, discard remaining beats, go to IDLE. done is not pulsed.
- Ack in the same cycle the counter reaches TIMEOUT: ack wins, no err.
- wbm_ack_i while stb is low is ignored.
- cmd_ready and wr_ready are 0 while rst is high.

## Timing
- Reset values: every output 0, state IDLE. cmd_ready goes to 1 in the first cycle after rst deasserts.
- Write beat: wr handshake at edge N; stb is high from cycle N+1. Ack sampled at edge M; stb is low in cycle M+1.
- Read beat: ack at edge M; rd_valid is high in cycle M+1. The rd handshake at edge K re-raises stb in cycle K+1 if beats remain.
- stb is low for at least one cycle between beats.
- Minimum beat period with a 1-cycle slave: 3 cycles.
- done/err rise in the cycle after the final ack (write) or final rd handshake (read).
- Reset mid-command: cyc/stb are 0 after the rst edge, with no done/err pulse.

## Structure
- Package wb_cmd_master_pkg holds:
  - the state enum (IDLE, WDATA, BUS, RSP);
  - WB_STRIDE = 4;
  - TO_W = $clog2(TIMEOUT+1).
- One sub-module, wbm_timeout_cnt: inputs clear and run, output expired at count == TIMEOUT.
- The FSM, address/beat counters and data latches stay in the top module.

## Test plan
- Single write: cmd adr 0x38000000, sel 0xF, len 0, wr_data 0xDEADBEEF; slave acks after 11 cycles. Expect exactly one stb pulse with dat_o 0xDEADBEEF and we=1, done 1 cycle after ack, err never.
- Burst read: adr 0x38000010, len 3; slave returns data = adr; rd_ready held low 3 cycles on beat 2. Expect adr 0x..10/14/18/1C, rd_data equal to adr, stb low throughout the stall, cyc high throughout, one done.
- Timeout: TIMEOUT=16, slave never acks. Expect stb high for exactly 16 cycles, then cyc/stb 0, err pulse, no rd_valid, cmd_ready 1 next cycle.
- Ack coincident with timeout: ack on the 16th BUS cycle. Expect beat completes, done, no err.
- Reset during beat 2 of a 4-beat write. Expect cyc/stb/wr_ready 0 the next cycle, no done/err, and a fresh command then accepted normally.
- Address wrap with sel: adr 0xFFFFFFFC, len 1, sel 0x3. Expect adr 0xFFFFFFFC then 0x00000000, sel_o 0x3 on both beats.
